cache_control4: RTL and testbench
=================================

Name: cache_control4

Overview:
- Sequencing FSM for the 4-way set-associative L1 cache: 8 sets, 128-bit lines, 9-bit tags, 16-bit LC-3b address split into 9-bit tag, 3-bit index and 4-bit offset.
- Consumes the hit detector's hit flag and one-hot way vector, plus per-way valid/dirty of the indexed set.
- Drives the array load strobes, datapath mux selects and the physical-memory handshake.
- Owns the pseudo-LRU state for all sets: 3 bits per set, 24 flops.

Parameters:
- NUM_SETS, 8, number of sets; PLRU storage depth.
- INDEX_W, 3, index width; log2(NUM_SETS).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_resp  out  1  request complete this cycle.
- index  in  INDEX_W  set index of current CPU address.
- hit  in  1  hit-detector hit flag.
- hit_direction  in  4  one-hot hit way.
- valid  in  4  valid bits of indexed set, bit i = way i.
- dirty  in  4  dirty bits of indexed set.
- pmem_resp  in  1  physical memory transfer done.
- pmem_read  out  1  physical memory line read strobe.
- pmem_write  out  1  physical memory line write strobe.
- pmem_addr_sel  out  1  0 = CPU tag/index, 1 = victim tag/index.
- data_in_sel  out  1  0 = CPU write-merged line, 1 = pmem line.
- load_data  out  4  per-way data array write enable.
- load_tag  out  4  per-way tag+valid write (valid written 1).
- load_dirty  out  4  per-way dirty write enable.
- dirty_in  out  1  value written by load_dirty.
- way_sel  out  2  way index for read-out / writeback data mux.

Behaviour:
- Outputs are combinational from state and inputs; only state, victim and PLRU are registered.
- States: CHECK, WRITEBACK, FETCH.
- Reset: state = CHECK, victim = 0, all PLRU bits = 0.
- Reset mid-miss: returns to CHECK on the next edge; pmem strobes drop that cycle; no array writes occur.
- Default outputs are all 0.
- Request: req = mem_read | mem_write. Both asserted is treated as a write.
- hw = index of the lowest set bit of hit_direction (priority if the vector is not one-hot).

CHECK:
- req & hit: mem_resp = 1 in the same cycle; way_sel = hw; PLRU[index] updated with hw.
- Write hit, additionally: load_data[hw] = 1, data_in_sel = 0, load_dirty[hw] = 1, dirty_in = 1.
- Remain in CHECK. Hit latency is 0 cycles (combinational response).
- req & !hit:
  - Victim = lowest-index way with valid = 0 if any; otherwise the PLRU choice. Victim is registered.
  - Next state is WRITEBACK if valid[v] & dirty[v], else FETCH.
  - mem_resp = 0.
- !req: idle; no PLRU change.

WRITEBACK:
- pmem_write = 1, pmem_addr_sel = 1, way_sel = victim.
- On pmem_resp: load_dirty[victim] = 1, dirty_in = 0; go to FETCH.
- Otherwise hold.

FETCH:
- pmem_read = 1, pmem_addr_sel = 0, way_sel = victim.
- On pmem_resp: load_data[victim] = load_tag[victim] = load_dirty[victim] = 1, dirty_in = 0, data_in_sel = 1; go to CHECK.
- The request then hits in the following cycle and completes via the CHECK rules; a write merges and sets dirty there.

Miss handling:
- Clean miss: mem_resp 1 cycle after the FETCH pmem_resp.
- Dirty miss: adds the WRITEBACK transfer.
- CPU dropping req mid-miss: the pmem transaction is still completed and the line installed; no mem_resp.

PLRU (per set, bits b0 b1 b2):
- Victim choice: b0 = 0 selects ways 0/1 (b1 = 0 → way0, 1 → way1); b0 = 1 selects ways 2/3 (b2 = 0 → way2, 1 → way3).
- Update on access to way w:
  - w = 0: b0 = 1, b1 = 1.
  - w = 1: b0 = 1, b1 = 0.
  - w = 2: b0 = 0, b2 = 1.
  - w = 3: b0 = 0, b2 = 0.
- PLRU is updated only on CHECK hits, never on fill.

Test Plan:
- Reset held 2 cycles during FETCH with pmem_resp = 0 → next cycle state CHECK, pmem_read = 0, all outputs 0, PLRU set 5 = 000.
- Read, index 3, hit_direction = 0100 → mem_resp = 1 same cycle, way_sel = 2, no load_*; PLRU[3] becomes b0 = 0, b2 = 1.
- Write, index 1, hit_direction = 0001 → mem_resp = 1, load_data = 0001, load_dirty = 0001, dirty_in = 1, data_in_sel = 0.
- Read miss, index 2, valid = 1011, dirty = 1111 → victim way 2, FETCH; pmem_read held 5 cycles; on pmem_resp: load_data = load_tag = 0100, data_in_sel = 1; next cycle with hit = 1 → mem_resp = 1.
- Write miss, index 0, valid = 1111, dirty = 0010, PLRU[0] = 000 → victim way1 (b0 = 0, b1 = 0 → way0? no): preload PLRU[0] via hit to way0 (→ b0 = 1, b1 = 1), then with PLRU b0 = 0, b1 = 1 from a way2 hit → victim way1, dirty → WRITEBACK.
  - pmem_write = 1, pmem_addr_sel = 1, way_sel = 1.
  - On pmem_resp: load_dirty = 0010, dirty_in = 0, then FETCH.
  - After fill, write hit sets dirty = 1.
- CPU drops mem_read during FETCH → pmem_read stays 1 until pmem_resp, line installed, mem_resp never asserts, returns to CHECK idle.

Source files
------------

// File: rtl/cache_control4.sv
// cache_control4: sequencing FSM for a 4-way set-associative L1 cache.
// Handles hit completion, dirty-victim writeback, line fill and the
// per-set tree pseudo-LRU. Outputs are combinational from state and inputs.
module cache_control4 #(
  parameter int NUM_SETS = 8,
  parameter int INDEX_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  output logic               mem_resp,
  input  logic [INDEX_W-1:0] index,
  input  logic               hit,
  input  logic [3:0]         hit_direction,
  input  logic [3:0]         valid,
  input  logic [3:0]         dirty,
  input  logic               pmem_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic               pmem_addr_sel,
  output logic               data_in_sel,
  output logic [3:0]         load_data,
  output logic [3:0]         load_tag,
  output logic [3:0]         load_dirty,
  output logic               dirty_in,
  output logic [1:0]         way_sel
);

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  state_t     state_reg;
  logic [1:0] victim_reg;
  // PLRU bits per set: [0] = root, [1] = ways 0/1 leaf, [2] = ways 2/3 leaf
  logic [2:0] plru_reg [NUM_SETS];

  logic       req;
  logic       is_write;
  logic [1:0] hw;
  logic [3:0] hw_onehot;
  logic [3:0] victim_onehot;
  logic [2:0] plru_cur;
  logic [2:0] plru_next;
  logic [1:0] plru_way;
  logic [1:0] victim_next;
  logic       plru_touch;

  assign req           = mem_read | mem_write;
  assign is_write      = mem_write;
  assign hw_onehot     = 4'b0001 << hw;
  assign victim_onehot = 4'b0001 << victim_reg;
  assign plru_cur      = plru_reg[index];
  assign plru_touch    = (state_reg == CHECK) && req && hit;

  // Hit way: lowest set bit of the hit vector, so a non-one-hot vector still resolves
  always_comb begin
    hw = 2'd0;
    if (hit_direction[0])      hw = 2'd0;
    else if (hit_direction[1]) hw = 2'd1;
    else if (hit_direction[2]) hw = 2'd2;
    else if (hit_direction[3]) hw = 2'd3;
  end

  // Victim: first invalid way wins over the PLRU tree walk
  always_comb begin
    plru_way = plru_cur[0] ? (plru_cur[2] ? 2'd3 : 2'd2)
                           : (plru_cur[1] ? 2'd1 : 2'd0);
    if (!valid[0])      victim_next = 2'd0;
    else if (!valid[1]) victim_next = 2'd1;
    else if (!valid[2]) victim_next = 2'd2;
    else if (!valid[3]) victim_next = 2'd3;
    else                victim_next = plru_way;
  end

  // PLRU update: point the tree away from the way just accessed
  always_comb begin
    plru_next = plru_cur;
    case (hw)
      2'd0: begin plru_next[0] = 1'b1; plru_next[1] = 1'b1; end
      2'd1: begin plru_next[0] = 1'b1; plru_next[1] = 1'b0; end
      2'd2: begin plru_next[0] = 1'b0; plru_next[2] = 1'b1; end
      default: begin plru_next[0] = 1'b0; plru_next[2] = 1'b0; end
    endcase
  end

  // Control outputs; forced quiet while reset is asserted so no strobe or array write leaks
  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    data_in_sel   = 1'b0;
    load_data     = 4'b0000;
    load_tag      = 4'b0000;
    load_dirty    = 4'b0000;
    dirty_in      = 1'b0;
    way_sel       = 2'd0;
    if (!rst) begin
      case (state_reg)
        CHECK: begin
          if (req && hit) begin
            mem_resp = 1'b1;
            way_sel  = hw;
            if (is_write) begin
              load_data  = hw_onehot;
              load_dirty = hw_onehot;
              dirty_in   = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = victim_reg;
          if (pmem_resp) load_dirty = victim_onehot;
        end
        FETCH: begin
          pmem_read = 1'b1;
          way_sel   = victim_reg;
          if (pmem_resp) begin
            load_data   = victim_onehot;
            load_tag    = victim_onehot;
            load_dirty  = victim_onehot;
            data_in_sel = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and victim register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= CHECK;
      victim_reg <= 2'd0;
    end else begin
      case (state_reg)
        CHECK: begin
          if (req && !hit) begin
            victim_reg <= victim_next;
            state_reg  <= (valid[victim_next] && dirty[victim_next]) ? WRITEBACK : FETCH;
          end
        end
        WRITEBACK: if (pmem_resp) state_reg <= FETCH;
        FETCH:     if (pmem_resp) state_reg <= CHECK;
        default:   state_reg <= CHECK;
      endcase
    end
  end

  // One PLRU entry per set, touched only by a CHECK hit on that set
  generate
    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_plru
      always_ff @(posedge clk) begin
        if (rst)
          plru_reg[gi] <= 3'b000;
        else if (plru_touch && (index == INDEX_W'(gi)))
          plru_reg[gi] <= plru_next;
      end
    end
  endgenerate

endmodule

// File: tb/tb_cache_control4.sv
// tb_cache_control4: directed vector table for cache_control4 plus
// hand-written sequences for reset during a fill and a dropped request.
module tb_cache_control4;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read, mem_write, mem_resp;
  logic [2:0] index;
  logic       hit;
  logic [3:0] hit_direction, valid, dirty;
  logic       pmem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel;
  logic [3:0] load_data, load_tag, load_dirty;
  logic       dirty_in;
  logic [1:0] way_sel;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cache_control4 #(.NUM_SETS(8), .INDEX_W(3)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .index(index), .hit(hit), .hit_direction(hit_direction),
    .valid(valid), .dirty(dirty), .pmem_resp(pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr_sel(pmem_addr_sel), .data_in_sel(data_in_sel),
    .load_data(load_data), .load_tag(load_tag), .load_dirty(load_dirty),
    .dirty_in(dirty_in), .way_sel(way_sel)
  );

  typedef struct {
    string       name;
    logic        rs, rd, wr;
    logic [2:0]  idx;
    logic        ht;
    logic [3:0]  hd, v, d;
    logic        pr;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[$];

  // {resp, pread, pwrite, addr_sel, data_sel, load_data, load_tag, load_dirty, dirty_in, way_sel}
  function automatic logic [19:0] eo(logic resp, logic prd, logic pwr, logic asel, logic dsel,
                                     logic [3:0] ld, logic [3:0] lt, logic [3:0] ldy,
                                     logic din, logic [1:0] ws);
    return {resp, prd, pwr, asel, dsel, ld, lt, ldy, din, ws};
  endfunction

  function automatic vec_t mk(string nm, logic rs, logic rd, logic wr, logic [2:0] idx,
                              logic ht, logic [3:0] hd, logic [3:0] v, logic [3:0] d,
                              logic pr, logic [19:0] e);
    vec_t t;
    t.name = nm; t.rs = rs; t.rd = rd; t.wr = wr; t.idx = idx; t.ht = ht;
    t.hd = hd; t.v = v; t.d = d; t.pr = pr; t.exp = e;
    return t;
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, then advance past the edge
  task automatic apply(input vec_t t);
    logic [19:0] got;
    rst = t.rs; mem_read = t.rd; mem_write = t.wr; index = t.idx; hit = t.ht;
    hit_direction = t.hd; valid = t.v; dirty = t.d; pmem_resp = t.pr;
    #3;
    got = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel,
           load_data, load_tag, load_dirty, dirty_in, way_sel};
    tests_run++;
    if (got !== t.exp) begin
      tests_failed++;
      $display("FAIL %s: got %05h required %05h", t.name, got, t.exp);
    end else begin
      $display("[TB] ok   %s: outputs %05h", t.name, got);
    end
    @(posedge clk); #1;
  endtask

  localparam logic [19:0] Z = 20'h0;

  initial begin
    rst = 1'b1; mem_read = 0; mem_write = 0; index = 0; hit = 0;
    hit_direction = 0; valid = 0; dirty = 0; pmem_resp = 0;
    @(posedge clk); #1;

    // Main vector table, applied cycle by cycle from reset
    tbl.push_back(mk("reset_quiet",     1,1,0,3'd0,1,4'b0001,4'hF,4'h0,1, Z));
    tbl.push_back(mk("reset_quiet2",    1,0,1,3'd0,1,4'b0001,4'hF,4'hF,0, Z));
    tbl.push_back(mk("idle",            0,0,0,3'd0,0,4'b0000,4'hF,4'h0,0, Z));
    tbl.push_back(mk("rd_hit_i3_w2",    0,1,0,3'd3,1,4'b0100,4'hF,4'h0,0, eo(1,0,0,0,0,0,0,0,0,2)));
    tbl.push_back(mk("wr_hit_i1_w0",    0,0,1,3'd1,1,4'b0001,4'hF,4'h0,0, eo(1,0,0,0,0,4'b0001,0,4'b0001,1,0)));
    tbl.push_back(mk("rd_miss_i2",      0,1,0,3'd2,0,4'b0000,4'b1011,4'hF,0, Z));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk("fetch_wait_i2", 0,1,0,3'd2,0,4'b0000,4'b1011,4'hF,0, eo(0,1,0,0,0,0,0,0,0,2)));
    tbl.push_back(mk("fetch_done_i2",   0,1,0,3'd2,0,4'b0000,4'b1011,4'hF,1, eo(0,1,0,0,1,4'b0100,4'b0100,4'b0100,0,2)));
    tbl.push_back(mk("rd_after_fill",   0,1,0,3'd2,1,4'b0100,4'hF,4'hF,0, eo(1,0,0,0,0,0,0,0,0,2)));
    // set 1 PLRU after way0 write hit: b0=1 b2=0 -> way2
    tbl.push_back(mk("rd_miss_i1_plru", 0,1,0,3'd1,0,4'b0000,4'hF,4'h0,0, Z));
    tbl.push_back(mk("fetch_i1_w2",     0,1,0,3'd1,0,4'b0000,4'hF,4'h0,1, eo(0,1,0,0,1,4'b0100,4'b0100,4'b0100,0,2)));
    tbl.push_back(mk("rd_hit_i1_w2",    0,1,0,3'd1,1,4'b0100,4'hF,4'h0,0, eo(1,0,0,0,0,0,0,0,0,2)));
    // set 0: hit way0 then way2 -> b0=0 b1=1 -> victim way1
    tbl.push_back(mk("rd_hit_i0_w0",    0,1,0,3'd0,1,4'b0001,4'hF,4'h0,0, eo(1,0,0,0,0,0,0,0,0,0)));
    tbl.push_back(mk("rd_hit_i0_w2",    0,1,0,3'd0,1,4'b0100,4'hF,4'h0,0, eo(1,0,0,0,0,0,0,0,0,2)));
    tbl.push_back(mk("wr_miss_i0",      0,0,1,3'd0,0,4'b0000,4'hF,4'b0010,0, Z));
    tbl.push_back(mk("wb_wait_a",       0,0,1,3'd0,0,4'b0000,4'hF,4'b0010,0, eo(0,0,1,1,0,0,0,0,0,1)));
    tbl.push_back(mk("wb_wait_b",       0,0,1,3'd0,0,4'b0000,4'hF,4'b0010,0, eo(0,0,1,1,0,0,0,0,0,1)));
    tbl.push_back(mk("wb_done",         0,0,1,3'd0,0,4'b0000,4'hF,4'b0010,1, eo(0,0,1,1,0,0,0,4'b0010,0,1)));
    tbl.push_back(mk("fetch_wait_i0",   0,0,1,3'd0,0,4'b0000,4'hF,4'b0000,0, eo(0,1,0,0,0,0,0,0,0,1)));
    tbl.push_back(mk("fetch_done_i0",   0,0,1,3'd0,0,4'b0000,4'hF,4'b0000,1, eo(0,1,0,0,1,4'b0010,4'b0010,4'b0010,0,1)));
    tbl.push_back(mk("wr_hit_after",    0,0,1,3'd0,1,4'b0010,4'hF,4'b0000,0, eo(1,0,0,0,0,4'b0010,0,4'b0010,1,1)));
    tbl.push_back(mk("hit_not_onehot",  0,1,0,3'd4,1,4'b1010,4'hF,4'h0,0, eo(1,0,0,0,0,0,0,0,0,1)));
    tbl.push_back(mk("rd_wr_is_write",  0,1,1,3'd5,1,4'b1000,4'hF,4'h0,0, eo(1,0,0,0,0,4'b1000,0,4'b1000,1,3)));
    // set 1 now b0=0 b1=1 -> way1
    tbl.push_back(mk("rd_miss_i1_b",    0,1,0,3'd1,0,4'b0000,4'hF,4'h0,0, Z));
    tbl.push_back(mk("fetch_i1_w1",     0,1,0,3'd1,0,4'b0000,4'hF,4'h0,1, eo(0,1,0,0,1,4'b0010,4'b0010,4'b0010,0,1)));
    tbl.push_back(mk("idle2",           0,0,0,3'd1,0,4'b0000,4'hF,4'h0,0, Z));
    // invalid victim with dirty bit set must not write back
    tbl.push_back(mk("wr_miss_inv_dty", 0,0,1,3'd6,0,4'b0000,4'b0111,4'hF,0, Z));
    tbl.push_back(mk("fetch_i6_w3",     0,0,1,3'd6,0,4'b0000,4'b0111,4'hF,1, eo(0,1,0,0,1,4'b1000,4'b1000,4'b1000,0,3)));
    tbl.push_back(mk("wr_hit_i6_w3",    0,0,1,3'd6,1,4'b1000,4'hF,4'h0,0, eo(1,0,0,0,0,4'b1000,0,4'b1000,1,3)));

    foreach (tbl[i]) apply(tbl[i]);

    // Reset held two cycles during FETCH; set 5 PLRU must come back as 000
    apply(mk("s5_hit_w0",        0,1,0,3'd5,1,4'b0001,4'hF,4'h0,0, eo(1,0,0,0,0,0,0,0,0,0)));
    apply(mk("s5_miss_inv",      0,1,0,3'd5,0,4'b0000,4'b0000,4'h0,0, Z));
    apply(mk("s5_fetch",         0,1,0,3'd5,0,4'b0000,4'b0000,4'h0,0, eo(0,1,0,0,0,0,0,0,0,0)));
    apply(mk("s5_rst_a",         1,1,0,3'd5,0,4'b0000,4'b0000,4'h0,0, Z));
    apply(mk("s5_rst_b",         1,1,0,3'd5,0,4'b0000,4'b0000,4'h0,0, Z));
    apply(mk("s5_post_rst_idle", 0,0,0,3'd5,0,4'b0000,4'hF,4'h0,0, Z));
    apply(mk("s5_miss_full",     0,1,0,3'd5,0,4'b0000,4'hF,4'h0,0, Z));
    apply(mk("s5_plru_way0",     0,1,0,3'd5,0,4'b0000,4'hF,4'h0,1, eo(0,1,0,0,1,4'b0001,4'b0001,4'b0001,0,0)));

    // CPU drops the read during FETCH: fill completes, no mem_resp
    apply(mk("drop_miss_i7",     0,1,0,3'd7,0,4'b0000,4'b1110,4'h0,0, Z));
    apply(mk("drop_fetch_req",   0,1,0,3'd7,0,4'b0000,4'b1110,4'h0,0, eo(0,1,0,0,0,0,0,0,0,0)));
    for (int i = 0; i < 3; i++)
      apply(mk("drop_fetch_noreq", 0,0,0,3'd7,0,4'b0000,4'b1110,4'h0,0, eo(0,1,0,0,0,0,0,0,0,0)));
    apply(mk("drop_fetch_done",  0,0,0,3'd7,0,4'b0000,4'b1110,4'h0,1, eo(0,1,0,0,1,4'b0001,4'b0001,4'b0001,0,0)));
    apply(mk("drop_idle",        0,0,0,3'd7,1,4'b0001,4'hF,4'h0,0, Z));
    apply(mk("drop_then_hit",    0,1,0,3'd7,1,4'b0001,4'hF,4'h0,0, eo(1,0,0,0,0,0,0,0,0,0)));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
